// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and
// frame/oversampling constants.
package uart_pkg;

   // Receiver FSM states; the encoding is visible on uart_rx.state for checkers.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } rx_state_t;

   // Oversample ticks per bit period.
   localparam int OVERSAMPLE = 16;
   // Sample count at which the line is read (centre of the bit).
   localparam int MID_SAMPLE = 7;
   // Payload bits per frame.
   localparam int DATA_BITS  = 8;

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO. Pointers carry one extra wrap bit so that
// full and empty are told apart without a separate counter. A push while
// full is accepted only if a pop happens in the same cycle.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // When full, the slot being written is the head being popped this cycle.
   assign do_push = push && (!full || do_pop);
   // Head is presented whenever valid; forced to zero while empty.
   assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   // Pointer update; both wrap modulo DEPTH through the low AW bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage write; contents need no reset since empty masks the output.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: rxd synchroniser, baud tick generator, 16x oversampling
// frame FSM (8N1, LSB first) and a receive FIFO.
//
// Output handshake: rx_valid is high while the FIFO holds a byte and rx_data
// is then the oldest byte; a byte is consumed on every rising clk edge where
// rx_valid and rx_ready are both high. rx_valid never depends on rx_ready.
module uart_rx
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx_enable,
   input  logic [15:0] baud_div,
   input  logic        uart_rxd,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic        rx_busy,
   output logic        frame_err,
   output logic        overrun
);

   localparam int SAMP_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = $clog2(DATA_BITS);
   localparam logic [SAMP_W-1:0] SAMP_ONE = SAMP_W'(1);
   localparam logic [BIT_W-1:0]  BIT_ONE  = BIT_W'(1);
   localparam logic [SAMP_W-1:0] SAMP_MID = SAMP_W'(MID_SAMPLE);
   localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxd_s;
   rx_state_t              state;
   logic [15:0]            tick_cnt;
   logic                   tick;
   logic [SAMP_W-1:0]      samp_cnt;
   logic                   mid;
   logic [BIT_W-1:0]       bit_cnt;
   logic [DATA_BITS-1:0]   shift_q;
   logic                   push;
   logic                   pop;
   logic                   fifo_full;
   logic                   fifo_empty;

   assign rxd_s = sync_q[SYNC_STAGES-1];

   // Synchroniser chain for the asynchronous line; resets to the idle level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
      end else begin
         sync_q[0] <= uart_rxd;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   // Ticks only run inside a frame, so the first tick is baud_div+1 cycles
   // after the start edge was seen.
   assign tick = (state != IDLE) && (tick_cnt == baud_div);
   assign mid  = tick && (samp_cnt == SAMP_MID);

   // Baud tick counter: held at 0 in IDLE, which is the reload on frame start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt <= '0;
      end else if (!rx_enable || state == IDLE || tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 16'd1;
      end
   end

   // Frame FSM. samp_cnt free-wraps over 16 ticks so every mid-sample after
   // the start bit lands exactly one bit period after the previous one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         samp_cnt  <= '0;
         bit_cnt   <= '0;
         shift_q   <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         if (!rx_enable) begin
            state    <= IDLE;
            samp_cnt <= '0;
            bit_cnt  <= '0;
         end else begin
            if (tick) samp_cnt <= samp_cnt + SAMP_ONE;
            case (state)
               IDLE: begin
                  if (!rxd_s) begin
                     state    <= START;
                     samp_cnt <= '0;
                     bit_cnt  <= '0;
                  end
               end
               START: begin
                  if (mid) state <= rxd_s ? IDLE : DATA;
               end
               DATA: begin
                  if (mid) begin
                     shift_q <= {rxd_s, shift_q[DATA_BITS-1:1]};
                     bit_cnt <= bit_cnt + BIT_ONE;
                     if (bit_cnt == BIT_LAST) state <= STOP;
                  end
               end
               STOP: begin
                  if (mid) begin
                     if (rxd_s) begin
                        state <= IDLE;
                     end else begin
                        frame_err <= 1'b1;
                        state     <= WAIT_IDLE;
                     end
                  end
               end
               WAIT_IDLE: begin
                  if (rxd_s) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // A good stop bit at its mid-sample delivers the assembled byte.
   assign push     = rx_enable && (state == STOP) && mid && rxd_s;
   assign pop      = rx_valid && rx_ready;
   assign rx_valid = !fifo_empty;
   assign rx_busy  = (state != IDLE);

   // Overrun flags a byte lost to a full FIFO with no pop freeing a slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun <= 1'b0;
      end else begin
         overrun <= push && fifo_full && !pop;
      end
   end

   uart_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (shift_q),
      .pop       (pop),
      .rd_data   (rx_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set the receive FIFO depth in entries; it SHALL be a power of two and at least 2.
REQ-003 Parameter SYNC_STAGES, default 2, SHALL set the number of flops in the rxd synchroniser.
REQ-004 Port list, one per line: name, direction, width, meaning.
- clk  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- rx_enable  in  1  receiver enable
- baud_div  in  16  clk cycles per oversample tick, minus 1
- uart_rxd  in  1  asynchronous serial line, idle high
- rx_data  out  8  head-of-FIFO byte
- rx_valid  out  1  FIFO not empty
- rx_ready  in  1  consumer accepts rx_data
- rx_busy  out  1  FSM not in IDLE
- frame_err  out  1  one-cycle pulse on a bad stop bit
- overrun  out  1  one-cycle pulse when a byte is dropped because the FIFO is full

Function
REQ-005 uart_rxd SHALL pass through SYNC_STAGES flops reset to 1; the FSM SHALL use only the synchronised value (rxd_s).
REQ-006 The tick counter SHALL produce one tick every baud_div+1 clk cycles.
REQ-007 The tick counter SHALL reload to 0 in the cycle the FSM leaves IDLE, aligning ticks to the start edge.
REQ-008 There SHALL be 16 ticks per bit; a 4-bit sample counter SHALL select the mid-bit sample at count 7.
REQ-009 The FSM SHALL have states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-010 IDLE SHALL go to START when rxd_s is 0 and rx_enable is 1.
REQ-011 At the START mid-sample, the FSM SHALL go to DATA if rxd_s is 0; otherwise it SHALL return to IDLE as a glitch, with no flags.
REQ-012 DATA SHALL shift in 8 bits LSB first, one per mid-sample spaced 16 ticks apart, then go to STOP.
REQ-013 At the STOP mid-sample, if rxd_s is 1 the byte SHALL be pushed and the FSM SHALL return to IDLE.
REQ-014 At the STOP mid-sample, if rxd_s is 0 frame_err SHALL pulse, the byte SHALL be discarded and the FSM SHALL go to WAIT_IDLE.
REQ-015 WAIT_IDLE SHALL return to IDLE on the first cycle rxd_s is 1.
REQ-016 Push latency: rx_valid SHALL assert on the clk edge after the stop mid-sample cycle when the FIFO was empty.
REQ-017 The FIFO SHALL be show-ahead: rx_data SHALL equal the head entry whenever rx_valid is 1.
REQ-018 A pop SHALL occur iff rx_valid and rx_ready are both 1.
REQ-019 rx_data SHALL be don't-care when rx_valid is 0.
REQ-020 A push while the FIFO is full with no simultaneous pop SHALL drop the new byte, keep the FIFO contents unchanged and pulse overrun.
REQ-021 A push and a pop in the same cycle with the FIFO full SHALL both take effect, with no overrun.
REQ-022 A push and a pop in the same cycle with the FIFO empty SHALL NOT occur, because rx_valid is 0.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 Occupancy SHALL be tracked with one extra pointer bit to distinguish full from empty.
REQ-025 Deasserting rx_enable SHALL force the FSM to IDLE on the next edge, abort any frame in progress without flags, and retain FIFO contents.
REQ-026 Popping SHALL continue to work while rx_enable is 0.
REQ-027 A baud_div change SHALL take effect only from IDLE; a change mid-frame is a usage error and its behaviour is unspecified.
REQ-028 frame_err and overrun SHALL never be asserted for more than one cycle per event.

Reset
REQ-029 While rst_n is 0, all of the following SHALL hold: FSM in IDLE, counters at 0, FIFO empty, rx_valid=0, rx_busy=0, frame_err=0, overrun=0, rx_data=0, synchroniser flops at 1.
REQ-030 Reset assertion mid-frame SHALL discard the partial byte and all FIFO contents.
REQ-031 Reset deassertion SHALL be synchronised to clk by the integrating top level; the block SHALL NOT resynchronise it.

Structure
REQ-032 The shared package uart_pkg SHALL hold the rx_state_t enum, OVERSAMPLE=16, MID_SAMPLE=7 and DATA_BITS=8.
REQ-033 The FIFO SHALL be a separate sub-module, uart_sync_fifo, parameterised by width and depth, with full, empty, push and pop ports.
REQ-034 The FSM, tick counter and synchroniser SHALL reside in uart_rx.

Verification
REQ-035 Frame 0xA5, baud_div=3 (64 clk per bit), rx_ready=1: rx_data=0xA5 with a one-cycle rx_valid; no frame_err or overrun.
REQ-036 A 12-clk low pulse on uart_rxd from idle: no push, rx_busy returns to 0, no flags.
REQ-037 Frame 0x3C with stop bit 0: one frame_err pulse, rx_valid stays 0, and the next valid frame 0x55 is received correctly.
REQ-038 rx_ready=0, five frames 0x01..0x05: the FIFO holds 0x01..0x04, overrun pulses exactly once, and the later pops return 0x01..0x04 in order.
REQ-039 FIFO full, with rx_ready pulsed in the stop mid-sample cycle of frame 0x06: no overrun, and the pops return 0x02, 0x03, 0x04, 0x06.
REQ-040 rst_n low in the middle of the DATA state of frame 0x81: all outputs at reset values; after release, frame 0x7E is received correctly.
